// File: rtl/irq_controller.sv
// Eight-line interrupt controller: synchronised edge capture into a pending register,
// mask gating, lowest-index priority and a request/ack handshake with the microcode.
module irq_controller #(
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] VEC_BASE    = 8'h00
) (
  input  logic       clk,
  input  logic       arst_n,
  input  logic [7:0] irq_in,
  input  logic       mask_wrt,
  input  logic [7:0] z_bus,
  input  logic       int_ack,
  input  logic       clear_all_ints,
  output logic       int_request,
  output logic [7:0] int_vector,
  output logic [7:0] irq_status,
  output logic [7:0] irq_masks
);

  typedef enum logic [1:0] {IDLE, REQ, ACK} state_e;

  logic [SYNC_STAGES-1:0][7:0] sync_q, sync_d;
  logic [SYNC_STAGES:0]        ready_q, ready_d;
  logic [7:0] prev_q, prev_d;
  logic [7:0] pending_q, pending_d;
  logic [7:0] masks_q, masks_d;
  logic [7:0] vector_q, vector_d;
  logic       req_q, req_d;
  state_e     state_q, state_d;

  logic [7:0] synced, rise, active;
  logic [2:0] idx;
  logic       ack_fire;

  always_comb begin
    sync_d  = {sync_q[SYNC_STAGES-2:0], irq_in};
    synced  = sync_q[SYNC_STAGES-1];
    prev_d  = synced;
    ready_d = {ready_q[SYNC_STAGES-1:0], 1'b1};
    // Edge detection stays off until the synchroniser and edge flop hold real
    // post-reset samples, so a line already high at release is not an edge.
    rise    = ready_q[SYNC_STAGES] ? (synced & ~prev_q) : 8'h00;
  end

  always_comb begin
    active = pending_q & masks_q;
    idx    = 3'd0;
    for (int i = 7; i >= 0; i--)
      if (active[i]) idx = i[2:0];
  end

  assign ack_fire = (state_q == REQ) && int_ack;

  always_comb begin
    pending_d = pending_q;
    if (ack_fire) pending_d[idx] = 1'b0;
    pending_d = pending_d | rise;
    if (clear_all_ints) pending_d = 8'h00;
    masks_d = mask_wrt ? z_bus : masks_q;
  end

  always_comb begin
    state_d  = state_q;
    req_d    = req_q;
    vector_d = vector_q;
    case (state_q)
      IDLE: if (active != 8'h00) begin
        state_d = REQ;
        req_d   = 1'b1;
      end
      REQ: if (int_ack) begin
        state_d  = ACK;
        req_d    = 1'b0;
        vector_d = VEC_BASE + {3'b000, idx, 2'b00};
      end else if (active == 8'h00) begin
        state_d = IDLE;
        req_d   = 1'b0;
      end
      ACK: begin
        state_d = IDLE;
        req_d   = 1'b0;
      end
      default: begin
        state_d = IDLE;
        req_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      sync_q    <= '0;
      ready_q   <= '0;
      prev_q    <= 8'h00;
      pending_q <= 8'h00;
      masks_q   <= 8'h00;
      vector_q  <= VEC_BASE;
      req_q     <= 1'b0;
      state_q   <= IDLE;
    end else begin
      sync_q    <= sync_d;
      ready_q   <= ready_d;
      prev_q    <= prev_d;
      pending_q <= pending_d;
      masks_q   <= masks_d;
      vector_q  <= vector_d;
      req_q     <= req_d;
      state_q   <= state_d;
    end
  end

  assign int_request = req_q;
  assign int_vector  = vector_q;
  assign irq_status  = pending_q;
  assign irq_masks   = masks_q;

endmodule

// File: tb/tb_irq_controller.sv
// Directed table plus randomized run of irq_controller against a sample-history model.
module tb_irq_controller;
  localparam int         S  = 2;
  localparam logic [7:0] VB = 8'h00;

  logic       clk = 1'b0;
  logic       arst_n = 1'b0;
  logic [7:0] irq_in = 8'h00, z_bus = 8'h00;
  logic       mask_wrt = 1'b0, int_ack = 1'b0, clear_all_ints = 1'b0;
  logic       int_request;
  logic [7:0] int_vector, irq_status, irq_masks;

  irq_controller #(.SYNC_STAGES(S), .VEC_BASE(VB)) dut (
    .clk(clk), .arst_n(arst_n), .irq_in(irq_in), .mask_wrt(mask_wrt), .z_bus(z_bus),
    .int_ack(int_ack), .clear_all_ints(clear_all_ints), .int_request(int_request),
    .int_vector(int_vector), .irq_status(irq_status), .irq_masks(irq_masks));

  always #5 clk = ~clk;

  int n_vec = 0, n_err = 0;

  task automatic chk(input string nm, input logic [7:0] got, input logic [7:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h at %0t", nm, got, exp, $time);
    end
  endtask

  task automatic chk_all(input string tag, input logic [7:0] st, input logic rq,
                         input logic [7:0] vec, input logic [7:0] msk);
    chk({tag, " status"}, irq_status, st);
    chk({tag, " request"}, {7'b0, int_request}, {7'b0, rq});
    chk({tag, " vector"}, int_vector, vec);
    chk({tag, " masks"}, irq_masks, msk);
  endtask

  typedef struct {
    logic [7:0] irq; logic mw; logic [7:0] z; logic ack; logic clr;
    logic [7:0] st;  logic rq; logic [7:0] vec; logic [7:0] msk;
  } row_t;
  row_t tbl[$];

  function automatic void add(input logic [7:0] irq, input logic mw, input logic [7:0] z,
                              input logic ack, input logic clr, input logic [7:0] st,
                              input logic rq, input logic [7:0] vec, input logic [7:0] msk);
    row_t r;
    r.irq = irq; r.mw = mw; r.z = z; r.ack = ack; r.clr = clr;
    r.st = st; r.rq = rq; r.vec = vec; r.msk = msk;
    tbl.push_back(r);
  endfunction

  // Reference model: the pending bit for line i sets at edge k when the input sampled
  // at edge k-S was high and the one sampled at k-S-1 was low, both taken since reset.
  logic [7:0] hist[$];
  logic [7:0] m_pend, m_mask, m_vec;
  bit         m_req;
  int         m_block;

  function automatic void m_reset();
    hist.delete();
    m_pend = 8'h00; m_mask = 8'h00; m_vec = VB; m_req = 1'b0; m_block = 0;
  endfunction

  function automatic void m_edge();
    logic [7:0] act, rise, np;
    int idx;
    act = m_pend & m_mask;
    idx = 0;
    for (int i = 0; i < 8; i++) if (act[i]) begin idx = i; break; end
    hist.push_back(irq_in);
    if (hist.size() > S + 2) void'(hist.pop_front());
    rise = 8'h00;
    if (hist.size() >= S + 2)
      rise = hist[hist.size()-1-S] & ~hist[hist.size()-2-S];
    np = m_pend;
    if (m_req && int_ack) begin
      m_vec = VB + 8'(idx * 4);
      np[idx] = 1'b0;
      m_req = 1'b0;
      m_block = 1;
    end else if (m_block > 0) begin
      m_req = 1'b0;
      m_block--;
    end else begin
      m_req = (act != 8'h00);
    end
    np = np | rise;
    if (clear_all_ints) np = 8'h00;
    m_pend = np;
    if (mask_wrt) m_mask = z_bus;
  endfunction

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    // Reset with all lines high; release must not create pending bits.
    irq_in = 8'hFF;
    repeat (3) @(negedge clk);
    chk_all("reset-held", 8'h00, 1'b0, VB, 8'h00);
    arst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk_all("reset-release", 8'h00, 1'b0, VB, 8'h00);
    end
    irq_in = 8'h00;
    repeat (5) tick();

    // single irq 3
    add(8'h00,1,8'h08,0,0, 8'h00,0,8'h00,8'h08);
    add(8'h08,0,8'h00,0,0, 8'h00,0,8'h00,8'h08);
    add(8'h00,0,8'h00,0,0, 8'h00,0,8'h00,8'h08);
    add(8'h00,0,8'h00,0,0, 8'h08,0,8'h00,8'h08);
    add(8'h00,0,8'h00,0,0, 8'h08,1,8'h00,8'h08);
    add(8'h00,0,8'h00,1,0, 8'h00,0,8'h0C,8'h08);
    add(8'h00,0,8'h00,0,0, 8'h00,0,8'h0C,8'h08);
    // priority 1 over 5
    add(8'h00,1,8'hFF,0,0, 8'h00,0,8'h0C,8'hFF);
    add(8'h22,0,8'h00,0,0, 8'h00,0,8'h0C,8'hFF);
    add(8'h00,0,8'h00,0,0, 8'h00,0,8'h0C,8'hFF);
    add(8'h00,0,8'h00,0,0, 8'h22,0,8'h0C,8'hFF);
    add(8'h00,0,8'h00,0,0, 8'h22,1,8'h0C,8'hFF);
    add(8'h00,0,8'h00,1,0, 8'h20,0,8'h04,8'hFF);
    add(8'h00,0,8'h00,0,0, 8'h20,0,8'h04,8'hFF);
    add(8'h00,0,8'h00,0,0, 8'h20,1,8'h04,8'hFF);
    add(8'h00,0,8'h00,1,0, 8'h00,0,8'h14,8'hFF);
    add(8'h00,0,8'h00,0,0, 8'h00,0,8'h14,8'hFF);
    // masked line 2, then unmask
    add(8'h00,1,8'h00,0,0, 8'h00,0,8'h14,8'h00);
    add(8'h04,0,8'h00,0,0, 8'h00,0,8'h14,8'h00);
    add(8'h00,0,8'h00,0,0, 8'h00,0,8'h14,8'h00);
    add(8'h00,0,8'h00,0,0, 8'h04,0,8'h14,8'h00);
    add(8'h00,0,8'h00,0,0, 8'h04,0,8'h14,8'h00);
    add(8'h00,1,8'h04,0,0, 8'h04,0,8'h14,8'h04);
    add(8'h00,0,8'h00,0,0, 8'h04,1,8'h14,8'h04);
    add(8'h00,0,8'h00,1,0, 8'h00,0,8'h08,8'h04);
    add(8'h00,0,8'h00,0,0, 8'h00,0,8'h08,8'h04);
    // new edge on line 0 coincides with its ack
    add(8'h00,1,8'h01,0,0, 8'h00,0,8'h08,8'h01);
    add(8'h01,0,8'h00,0,0, 8'h00,0,8'h08,8'h01);
    add(8'h00,0,8'h00,0,0, 8'h00,0,8'h08,8'h01);
    add(8'h00,0,8'h00,0,0, 8'h01,0,8'h08,8'h01);
    add(8'h01,0,8'h00,0,0, 8'h01,1,8'h08,8'h01);
    add(8'h00,0,8'h00,0,0, 8'h01,1,8'h08,8'h01);
    add(8'h00,0,8'h00,1,0, 8'h01,0,8'h00,8'h01);
    add(8'h00,0,8'h00,0,0, 8'h01,0,8'h00,8'h01);
    add(8'h00,0,8'h00,0,0, 8'h01,1,8'h00,8'h01);
    add(8'h00,0,8'h00,1,0, 8'h00,0,8'h00,8'h01);
    add(8'h00,0,8'h00,0,0, 8'h00,0,8'h00,8'h01);
    // clear_all beats an edge on line 6
    add(8'h40,0,8'h00,0,0, 8'h00,0,8'h00,8'h01);
    add(8'h00,0,8'h00,0,0, 8'h00,0,8'h00,8'h01);
    add(8'h00,0,8'h00,0,1, 8'h00,0,8'h00,8'h01);
    add(8'h00,0,8'h00,0,0, 8'h00,0,8'h00,8'h01);
    // line 3 up to ack, ending in the ACK state
    add(8'h00,1,8'h08,0,0, 8'h00,0,8'h00,8'h08);
    add(8'h08,0,8'h00,0,0, 8'h00,0,8'h00,8'h08);
    add(8'h00,0,8'h00,0,0, 8'h00,0,8'h00,8'h08);
    add(8'h00,0,8'h00,0,0, 8'h08,0,8'h00,8'h08);
    add(8'h00,0,8'h00,0,0, 8'h08,1,8'h00,8'h08);
    add(8'h00,0,8'h00,1,0, 8'h00,0,8'h0C,8'h08);

    foreach (tbl[i]) begin
      irq_in = tbl[i].irq; mask_wrt = tbl[i].mw; z_bus = tbl[i].z;
      int_ack = tbl[i].ack; clear_all_ints = tbl[i].clr;
      tick();
      chk_all($sformatf("row%0d", i), tbl[i].st, tbl[i].rq, tbl[i].vec, tbl[i].msk);
    end
    mask_wrt = 1'b0; int_ack = 1'b0; clear_all_ints = 1'b0; z_bus = 8'h00;

    // Reset in the ACK cycle with line 3 held high through release.
    irq_in = 8'h08;
    arst_n = 1'b0;
    #1 chk_all("reset-mid-ack", 8'h00, 1'b0, VB, 8'h00);
    repeat (2) tick();
    arst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk_all("post-ack-reset", 8'h00, 1'b0, VB, 8'h00);
    end

    // Randomized run against the model.
    arst_n = 1'b0; m_reset();
    #1 arst_n = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 499) == 0) begin
        arst_n = 1'b0; m_reset();
        #1 chk_all("rand-reset", m_pend, m_req, m_vec, m_mask);
        #1 arst_n = 1'b1;
      end
      irq_in         = irq_in ^ 8'($urandom & $urandom & $urandom);
      int_ack        = ($urandom_range(0, 3) == 0);
      clear_all_ints = ($urandom_range(0, 39) == 0);
      mask_wrt       = ($urandom_range(0, 19) == 0);
      z_bus          = 8'($urandom);
      @(posedge clk);
      m_edge();
      @(negedge clk);
      chk_all("rand", m_pend, m_req, m_vec, m_mask);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
